execute_arbiter: RTL and testbench

Shares one `Execute` stage (ALU, `WIDTH`-bit operands, 4-bit `aluControl`, N/Z/V/C flags) between two requesters, e.g. the main pipeline issue port and an auxiliary address/compare unit. It arbitrates round-robin, registers the granted operands into the ALU, captures result and flags one cycle later, and returns them on a valid/ready response port tagged with the requester ID. It sits directly in front of `Execute`, which stays purely combinational.

---
 rtl/execute_arbiter.sv | 111 +++++++++++
 tb/tb_execute_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_arbiter.sv
// Round-robin front end sharing one combinational Execute stage between two
// requesters; registers operands, captures result/flags, returns tagged response.
module execute_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             req0Valid,
    input  logic             req1Valid,
    output logic             req0Ready,
    output logic             req1Ready,
    input  logic [WIDTH-1:0] req0Data1,
    input  logic [WIDTH-1:0] req0Data2,
    input  logic [WIDTH-1:0] req1Data1,
    input  logic [WIDTH-1:0] req1Data2,
    input  logic [3:0]       req0AluControl,
    input  logic [3:0]       req1AluControl,
    output logic [WIDTH-1:0] aluData1,
    output logic [WIDTH-1:0] aluData2,
    output logic [3:0]       aluControl,
    input  logic [WIDTH-1:0] aluOutput,
    input  logic             N,
    input  logic             Z,
    input  logic             V,
    input  logic             C,
    output logic             respValid,
    input  logic             respReady,
    output logic             respId,
    output logic [WIDTH-1:0] respResult,
    output logic             respN,
    output logic             respZ,
    output logic             respV,
    output logic             respC
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    state_t nextState;
    logic   lastGrant;
    logic   grant;
    logic   accept;

    // On a tie the requester that did not win last time gets the slot
    always_comb begin
        grant = 1'b0;
        if (req0Valid && req1Valid) begin
            grant = ~lastGrant;
        end else if (req1Valid) begin
            grant = 1'b1;
        end
    end

    assign accept    = (state == IDLE) && (req0Valid || req1Valid);
    assign req0Ready = accept && !grant;
    assign req1Ready = accept && grant;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (accept) nextState = EXEC;
            EXEC: nextState = RESP;
            RESP: if (respReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            aluData1   <= '0;
            aluData2   <= '0;
            aluControl <= '0;
            lastGrant  <= 1'b1;
            respId     <= 1'b0;
            respValid  <= 1'b0;
            respResult <= '0;
            respN      <= 1'b0;
            respZ      <= 1'b0;
            respV      <= 1'b0;
            respC      <= 1'b0;
        end else begin
            if (accept) begin
                aluData1   <= grant ? req1Data1 : req0Data1;
                aluData2   <= grant ? req1Data2 : req0Data2;
                aluControl <= grant ? req1AluControl : req0AluControl;
                lastGrant  <= grant;
                respId     <= grant;
            end
            if (state == EXEC) begin
                respResult <= aluOutput;
                respN      <= N;
                respZ      <= Z;
                respV      <= V;
                respC      <= C;
                respValid  <= 1'b1;
            end
            if (state == RESP && respReady) begin
                respValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_arbiter.sv
// Directed bench for execute_arbiter with a transaction-level reference model
// and a small Execute stand-in driving aluOutput and flags.
module tb_execute_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         nReset;
    logic         req0Valid, req1Valid, req0Ready, req1Ready;
    logic [W-1:0] req0Data1, req0Data2, req1Data1, req1Data2;
    logic [3:0]   req0AluControl, req1AluControl;
    logic [W-1:0] aluData1, aluData2, aluOutput;
    logic [3:0]   aluControl;
    logic         N, Z, V, C;
    logic         respValid, respReady, respId;
    logic [W-1:0] respResult;
    logic         respN, respZ, respV, respC;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    execute_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .nReset(nReset),
        .req0Valid(req0Valid), .req1Valid(req1Valid),
        .req0Ready(req0Ready), .req1Ready(req1Ready),
        .req0Data1(req0Data1), .req0Data2(req0Data2),
        .req1Data1(req1Data1), .req1Data2(req1Data2),
        .req0AluControl(req0AluControl), .req1AluControl(req1AluControl),
        .aluData1(aluData1), .aluData2(aluData2), .aluControl(aluControl),
        .aluOutput(aluOutput), .N(N), .Z(Z), .V(V), .C(C),
        .respValid(respValid), .respReady(respReady), .respId(respId),
        .respResult(respResult),
        .respN(respN), .respZ(respZ), .respV(respV), .respC(respC)
    );

    // Execute stand-in: 0 ADD, 1 SUB, 2 AND, 3 OR, else pass a. Returns {N,Z,V,C,res}
    function automatic logic [W+3:0] alu(input logic [3:0] ctl,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         v, c;
        v = 1'b0;
        c = 1'b0;
        case (ctl)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[W-1:0];
                c = wide[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            default: r = a;
        endcase
        return {r[W-1], (r == '0), v, c, r};
    endfunction

    assign {N, Z, V, C, aluOutput} = alu(aluControl, aluData1, aluData2);

    function automatic logic pick(input logic v0, input logic v1,
                                  input logic last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

    // Reference model: one outstanding transaction at a time
    logic         m_busy, m_rv, m_rid, m_last;
    logic [W-1:0] m_d1, m_d2, m_res;
    logic [3:0]   m_ctl, m_fl;
    int           cyc = 0;
    int           log_id[$];
    int           log_cyc[$];

    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            m_busy <= 1'b0;
            m_rv   <= 1'b0;
            m_rid  <= 1'b0;
            m_last <= 1'b1;
            m_d1   <= '0;
            m_d2   <= '0;
            m_ctl  <= '0;
            m_res  <= '0;
            m_fl   <= '0;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy) begin
                if (req0Valid || req1Valid) begin
                    if (pick(req0Valid, req1Valid, m_last)) begin
                        m_d1  <= req1Data1;
                        m_d2  <= req1Data2;
                        m_ctl <= req1AluControl;
                    end else begin
                        m_d1  <= req0Data1;
                        m_d2  <= req0Data2;
                        m_ctl <= req0AluControl;
                    end
                    m_last <= pick(req0Valid, req1Valid, m_last);
                    m_rid  <= pick(req0Valid, req1Valid, m_last);
                    m_busy <= 1'b1;
                    log_id.push_back(int'(pick(req0Valid, req1Valid, m_last)));
                    log_cyc.push_back(cyc);
                end
            end else if (!m_rv) begin
                m_rv <= 1'b1;
                {m_fl, m_res} <= alu(m_ctl, m_d1, m_d2);
            end else if (respReady) begin
                m_rv   <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req0Ready", 32'(req0Ready),
            32'(!m_busy && req0Valid && !pick(req0Valid, req1Valid, m_last)));
        chk("req1Ready", 32'(req1Ready),
            32'(!m_busy && req1Valid && pick(req0Valid, req1Valid, m_last)));
        chk("respValid", 32'(respValid), 32'(m_rv));
        chk("respId", 32'(respId), 32'(m_rid));
        chk("respResult", 32'(respResult), 32'(m_res));
        chk("respFlags", 32'({respN, respZ, respV, respC}), 32'(m_fl));
        chk("aluData1", 32'(aluData1), 32'(m_d1));
        chk("aluData2", 32'(aluData2), 32'(m_d2));
        chk("aluControl", 32'(aluControl), 32'(m_ctl));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set0(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] c);
        req0Data1 = a;
        req0Data2 = b;
        req0AluControl = c;
    endtask

    task automatic set1(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] c);
        req1Data1 = a;
        req1Data2 = b;
        req1AluControl = c;
    endtask

    int base;

    initial begin
        nReset = 1'b0;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        respReady = 1'b0;
        set0(8'h00, 8'h00, 4'd0);
        set1(8'h00, 8'h00, 4'd0);
        #12;
        chk("rst_respValid", 32'(respValid), 32'd0);
        chk("rst_aluData1", 32'(aluData1), 32'd0);
        nReset = 1'b1;
        tick();

        // single request: 5 + 3
        set0(8'h05, 8'h03, 4'd0);
        req0Valid = 1'b1;
        tick();
        req0Valid = 1'b0;
        tick();
        chk("single_valid", 32'(respValid), 32'd1);
        chk("single_id", 32'(respId), 32'd0);
        chk("single_result", 32'(respResult), 32'h08);
        chk("single_Z", 32'(respZ), 32'd0);
        respReady = 1'b1;
        tick();
        respReady = 1'b0;

        // flags: FF + 01
        set0(8'hFF, 8'h01, 4'd0);
        req0Valid = 1'b1;
        tick();
        req0Valid = 1'b0;
        tick();
        chk("flags_result", 32'(respResult), 32'h00);
        chk("flags_ZVC", 32'({respZ, respV, respC}), 32'b101);
        respReady = 1'b1;
        tick();
        respReady = 1'b0;

        // backpressure: req1 op held 5 cycles while req0 waits
        set1(8'h09, 8'h04, 4'd1);
        req1Valid = 1'b1;
        tick();
        req1Valid = 1'b0;
        set0(8'h0F, 8'h3C, 4'd2);
        req0Valid = 1'b1;
        tick();
        chk("bp_result", 32'(respResult), 32'h05);
        chk("bp_id", 32'(respId), 32'd1);
        base = log_id.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_readies", 32'({req0Ready, req1Ready}), 32'd0);
            chk("bp_held", 32'(respValid), 32'd1);
        end
        chk("bp_no_accept", 32'(log_id.size()), 32'(base));
        respReady = 1'b1;
        tick();
        chk("bp_idle", 32'({respValid, req0Ready}), 32'b01);
        tick();
        req0Valid = 1'b0;
        chk("bp_accept_id", 32'(log_id[base]), 32'd0);
        tick();
        chk("bp_and_result", 32'(respResult), 32'h0C);
        tick();
        respReady = 1'b0;

        // reset mid-RESP
        set1(8'h77, 8'h11, 4'd3);
        req1Valid = 1'b1;
        tick();
        req1Valid = 1'b0;
        tick();
        chk("pre_rst_id", 32'(respId), 32'd1);
        #2 nReset = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(respValid), 32'd0);
        chk("rst_mid_id", 32'(respId), 32'd0);
        chk("rst_mid_result", 32'(respResult), 32'd0);
        chk("rst_mid_alu", 32'({aluData1, aluData2, aluControl}), 32'd0);
        tick();
        nReset = 1'b1;
        tick(3);
        chk("rst_no_resp", 32'(respValid), 32'd0);

        // round-robin after reset
        base = log_id.size();
        set0(8'h10, 8'h20, 4'd0);
        set1(8'h80, 8'h80, 4'd0);
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        respReady = 1'b1;
        tick(12);
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        tick(3);
        chk("rr_count", 32'(log_id.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 32'(log_id[base+i]), 32'(i % 2));
            if (i > 0)
                chk("rr_spacing", 32'(log_cyc[base+i] - log_cyc[base+i-1]), 32'd3);
        end

        // lone requester then contention
        base = log_id.size();
        set1(8'h01, 8'h01, 4'd1);
        req1Valid = 1'b1;
        tick(9);
        chk("lone_count", 32'(log_id.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("lone_id", 32'(log_id[base+i]), 32'd1);
            if (i > 0)
                chk("lone_spacing", 32'(log_cyc[base+i] - log_cyc[base+i-1]), 32'd3);
        end
        base = log_id.size();
        req0Valid = 1'b1;
        tick();
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        chk("contend_id", 32'(log_id[base]), 32'd0);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
